// File: rtl/iir_tdm_sched_pkg.sv
// Shared constants, sample type and shift-add coefficient helpers for the TDM IIR scheduler.
package iir_tdm_sched_pkg;

    localparam int unsigned W       = 14;
    localparam int unsigned SW      = W + 1;
    localparam int unsigned N_CH    = 4;
    localparam int unsigned CH_W    = 2;

    localparam int unsigned XP_SH_A = 1;
    localparam int unsigned XP_SH_B = 2;
    localparam int unsigned Y2_SH_A = 1;
    localparam int unsigned Y2_SH_B = 4;

    typedef logic signed [SW-1:0] sample_t;
    typedef logic [CH_W-1:0]      ch_t;

    // Sums wrap to the sample width through the return type.
    function automatic sample_t mul_3_4(input sample_t v);
        return (v >>> XP_SH_A) + (v >>> XP_SH_B);
    endfunction

    function automatic sample_t mul_9_16(input sample_t v);
        return (v >>> Y2_SH_A) + (v >>> Y2_SH_B);
    endfunction

endpackage

// File: rtl/iir_tdm_sched_if.sv
// Producer-side request/sample bus and result bus of the TDM IIR scheduler.
interface iir_tdm_sched_if;
    import iir_tdm_sched_pkg::*;

    logic [N_CH-1:0]    req;
    logic [N_CH*SW-1:0] x_bus;
    logic [N_CH-1:0]    gnt;
    sample_t            y_out;
    logic               y_valid;
    ch_t                y_ch;

    modport master (
        output req, x_bus,
        input  gnt, y_out, y_valid, y_ch
    );

    modport slave (
        input  req, x_bus,
        output gnt, y_out, y_valid, y_ch
    );

endinterface

// File: rtl/iir_tdm_sched_rr_arb4.sv
// Combinational 4-way round-robin arbiter; the channel at i_ptr has highest priority.
module rr_arb4
    import iir_tdm_sched_pkg::*;
(
    input  logic [N_CH-1:0] i_elig,
    input  ch_t             i_ptr,
    output logic [N_CH-1:0] o_gnt
);

    ch_t  w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx = i_ptr + CH_W'(i);
            if (!w_found && i_elig[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iir_tdm_sched.sv
// Round-robin TDM scheduler sharing one two-stage look-ahead IIR datapath among four channels.
module iir_tdm_sched
    import iir_tdm_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    iir_tdm_sched_if.slave bus
);

    logic [N_CH-1:0] w_elig;
    logic [N_CH-1:0] w_gnt;
    logic            w_gnt_any;
    ch_t             w_gnt_idx;
    sample_t         w_x_sel;
    sample_t         w_t;
    sample_t         w_g;
    sample_t         w_y;
    logic [N_CH-1:0] w_busy_d;

    ch_t             r_ptr;
    logic [N_CH-1:0] r_busy;
    sample_t         r_xp [N_CH];
    sample_t         r_y1 [N_CH];
    sample_t         r_y2 [N_CH];

    logic            r_s1_vld;
    ch_t             r_s1_ch;
    sample_t         r_s1_x;
    sample_t         r_s1_xp;
    sample_t         r_s1_y2;

    sample_t         r_y_out;
    logic            r_y_valid;
    ch_t             r_y_ch;

    // Masking with reset keeps gnt low while reset is held.
    assign w_elig = bus.req & ~r_busy & {N_CH{~reset}};

    rr_arb4 u_arb (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt)
    );

    assign w_gnt_any = |w_gnt;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) w_gnt_idx = CH_W'(i);
        end
    end

    assign w_x_sel = bus.x_bus[w_gnt_idx*SW +: SW];

    assign w_t = r_s1_x + mul_3_4(r_s1_xp);
    assign w_g = mul_9_16(r_s1_y2);
    assign w_y = w_t + w_g;

    // Clear precedes set; the same channel can never be both, busy blocks the grant.
    always_comb begin
        w_busy_d = r_busy;
        if (r_y_valid) w_busy_d[r_y_ch] = 1'b0;
        if (w_gnt_any) w_busy_d[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_busy    <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_ch   <= '0;
            r_s1_x    <= '0;
            r_s1_xp   <= '0;
            r_s1_y2   <= '0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
            r_y_ch    <= '0;
        end else begin
            r_busy    <= w_busy_d;
            if (w_gnt_any) r_ptr <= w_gnt_idx + CH_W'(1);
            r_s1_vld  <= w_gnt_any;
            r_s1_ch   <= w_gnt_idx;
            r_s1_x    <= w_x_sel;
            r_s1_xp   <= r_xp[w_gnt_idx];
            r_s1_y2   <= r_y2[w_gnt_idx];
            r_y_valid <= r_s1_vld;
            if (r_s1_vld) begin
                r_y_out <= w_y;
                r_y_ch  <= r_s1_ch;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_xp[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            if (w_gnt_any) r_xp[w_gnt_idx] <= w_x_sel;
            if (r_s1_vld) begin
                r_y2[r_s1_ch] <= r_y1[r_s1_ch];
                r_y1[r_s1_ch] <= w_y;
            end
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.y_out   = r_y_out;
    assign bus.y_valid = r_y_valid;
    assign bus.y_ch    = r_y_ch;

endmodule

// File: tb/tb_iir_tdm_sched.sv
// Scoreboard bench for iir_tdm_sched: directed vectors with hand-computed results.
module tb_iir_tdm_sched;

    typedef struct packed {
        logic [1:0]  ch;
        logic [14:0] y;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    exp_t        q[$];
    logic [14:0] xs [4][8];
    logic [14:0] ys [4][8];
    int          nidx [4];
    int          ngr [4];
    int          gseq[$];

    iir_tdm_sched_if bus ();

    iir_tdm_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.y_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("y_out", {17'd0, bus.y_out}, {17'd0, e.y});
                chk("y_ch", {30'd0, bus.y_ch}, {30'd0, e.ch});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic clear_tables();
        bus.req   = '0;
        bus.x_bus = '0;
        gseq.delete();
        for (int c = 0; c < 4; c++) begin
            nidx[c] = 0;
            ngr[c]  = 0;
            for (int j = 0; j < 8; j++) begin
                xs[c][j] = '0;
                ys[c][j] = '0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Raise req and present the first sample for every channel with grants queued.
    task automatic arm();
        for (int c = 0; c < 4; c++) begin
            if (ngr[c] > 0) begin
                bus.req[c] = 1'b1;
                bus.x_bus[c*15 +: 15] = xs[c][0];
            end
        end
    endtask

    task automatic run(input string name);
        for (int k = 0; k < gseq.size(); k++) begin
            int g;
            exp_t e;
            @(negedge clk);
            g = gseq[k];
            chk({name, "_gnt"}, {28'd0, bus.gnt}, (g < 0) ? 32'd0 : (32'd1 << g));
            if (g >= 0) begin
                e.ch  = 2'(g);
                e.y   = ys[g][nidx[g]];
                e.cyc = cyc + 2;
                q.push_back(e);
                nidx[g]++;
            end
            @(posedge clk);
            #1;
            if (g >= 0) begin
                if (nidx[g] < ngr[g]) bus.x_bus[g*15 +: 15] = xs[g][nidx[g]];
                else bus.req[g] = 1'b0;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_drain"}, q.size(), 0);
    endtask

    task automatic setup_impulse();
        clear_tables();
        ngr[0] = 6;
        xs[0][0] = 15'd1024;
        ys[0][0] = 15'd1024;
        ys[0][1] = 15'd768;
        ys[0][2] = 15'd576;
        ys[0][3] = 15'd432;
        ys[0][4] = 15'd324;
        ys[0][5] = 15'd243;
        for (int k = 0; k < 16; k++) gseq.push_back((k % 3 == 0) ? 0 : -1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_tables();
        bus.req  = 4'hF;

        // Reset held with all requests high.
        repeat (4) begin
            @(negedge clk);
            chk("rst_gnt", {28'd0, bus.gnt}, 0);
            chk("rst_y_out", {17'd0, bus.y_out}, 0);
            chk("rst_y_valid", {31'd0, bus.y_valid}, 0);
            chk("rst_y_ch", {30'd0, bus.y_ch}, 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // All four held: rotation 0,1,2,3,0,1,2,3.
        clear_tables();
        for (int c = 0; c < 4; c++) begin
            ngr[c] = 2;
            xs[c][0] = 15'(100 * (c + 1));
        end
        ys[0][0] = 15'd100; ys[0][1] = 15'd75;
        ys[1][0] = 15'd200; ys[1][1] = 15'd150;
        ys[2][0] = 15'd300; ys[2][1] = 15'd225;
        ys[3][0] = 15'd400; ys[3][1] = 15'd300;
        for (int k = 0; k < 8; k++) gseq.push_back(k % 4);
        arm();
        run("all4");

        // Impulse on ch0.
        do_reset();
        setup_impulse();
        arm();
        run("impulse");

        // ch0 and ch1 only: idle slot every third cycle.
        do_reset();
        clear_tables();
        ngr[0] = 2; xs[0][0] = 15'd10; xs[0][1] = 15'd20;
        ngr[1] = 2; xs[1][0] = 15'd40; xs[1][1] = 15'd80;
        ys[0][0] = 15'd10; ys[0][1] = 15'd27;
        ys[1][0] = 15'd40; ys[1][1] = 15'd110;
        gseq.push_back(0); gseq.push_back(1); gseq.push_back(-1);
        gseq.push_back(0); gseq.push_back(1);
        arm();
        run("pair");

        // Wrap on ch2: 28669 fits 15 bits only as -4099.
        do_reset();
        clear_tables();
        ngr[2] = 2;
        xs[2][0] = 15'd16383; xs[2][1] = 15'd16383;
        ys[2][0] = 15'd16383; ys[2][1] = 15'd28669;
        gseq.push_back(2); gseq.push_back(-1); gseq.push_back(-1); gseq.push_back(2);
        arm();
        run("wrap");

        // Reset while a ch1 sample is in flight.
        do_reset();
        clear_tables();
        bus.req[1] = 1'b1;
        bus.x_bus[15 +: 15] = 15'd1000;
        @(negedge clk);
        chk("mid_gnt", {28'd0, bus.gnt}, 32'd2);
        @(posedge clk);
        #1;
        bus.req = '0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        setup_impulse();
        arm();
        run("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
